// File: rtl/counter_sched_pkg.sv
// Shared types and default sizing for the counter job scheduler.
// Contents: scheduler state encoding, default requester count and width.
`timescale 1ns/1ps
package counter_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/counter_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: rotate-priority encoder, purely combinational.
// Ports: req (requests), last_grant (pointer) -> gnt (one-hot), gnt_id.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic w_found;
    int   w_idx;

    // Search starts one past the last winner and wraps, so the most
    // recent owner has the lowest priority.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx = (int'(last_grant) + i) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = IDW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/counter_job_scheduler.sv
// Shares one up-counter among NREQ requesters as bounded, round-robin jobs.
// Ports: clk, reset (async high), req_valid/req_len/req_ready handshake,
//        busy, grant_id, count, done pulse, done_id.
`timescale 1ns/1ps
module counter_job_scheduler
    import counter_sched_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_len,
    output logic [NREQ-1:0]       req_ready,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic [WIDTH-1:0]      count,
    output logic                  done,
    output logic [IDW-1:0]        done_id
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_len;
    logic [WIDTH-1:0] r_count;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   r_last;
    logic             r_busy;
    logic             r_done;
    logic [IDW-1:0]   r_done_id;

    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_len_sel;

    rr_arbiter #(
        .NREQ       (NREQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last),
        .gnt        (w_gnt),
        .gnt_id     (w_gnt_id)
    );

    assign w_len_sel = req_len[w_gnt_id*WIDTH +: WIDTH];

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_accept  = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = w_gnt;
                w_accept  = (w_gnt != '0);
                if (w_accept) begin
                    w_next = (w_len_sel != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (r_count == r_len - WIDTH'(1)) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up
    // with the state they describe and never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_count    <= '0;
            r_grant_id <= '0;
            r_last     <= IDW'(NREQ - 1);
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
            if (w_accept) begin
                r_len      <= w_len_sel;
                r_grant_id <= w_gnt_id;
                r_last     <= w_gnt_id;
                r_count    <= '0;
            end else if (r_state == RUN && w_next == RUN) begin
                r_count <= r_count + WIDTH'(1);
            end
            // zero-length jobs reach DONE straight from the accept edge
            if (w_next == DONE) begin
                r_done_id <= w_accept ? w_gnt_id : r_grant_id;
            end
        end
    end

    assign busy     = r_busy;
    assign grant_id = r_grant_id;
    assign count    = r_count;
    assign done     = r_done;
    assign done_id  = r_done_id;

endmodule

// File: tb/tb_counter_job_scheduler.sv
// Testbench for counter_job_scheduler: directed scenarios plus random jobs.
// Expected behaviour comes from a job-timeline model (start cycle + length).
`timescale 1ns/1ps
module tb_counter_job_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_len = '0;
    logic [N-1:0]   req_ready;
    logic           busy;
    logic [1:0]     grant_id;
    logic [W-1:0]   count;
    logic           done;
    logic [1:0]     done_id;

    counter_job_scheduler #(
        .NREQ      (N),
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .busy      (busy),
        .grant_id  (grant_id),
        .count     (count),
        .done      (done),
        .done_id   (done_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: one job at a time on a cycle timeline
    int       cyc = 0;
    int       m_start = 0;
    int       m_len = 0;
    int       m_owner = 0;
    int       m_idle_at = 0;
    int       m_last = N - 1;
    int       m_grant = 0;
    logic [7:0] m_count = '0;

    // DUT-observed handshakes and done pulses
    int acc_id[$];
    int acc_cyc[$];
    int done_cyc[$];
    int n_g1 = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_len(input int i, input int l);
        req_len[i*W +: W] = W'(l);
    endtask

    task automatic clr_logs();
        acc_id.delete();
        acc_cyc.delete();
        done_cyc.delete();
        n_g1 = 0;
    endtask

    task automatic model_reset();
        m_idle_at = 0;
        m_last    = N - 1;
        m_grant   = 0;
        m_count   = '0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_cnt"}, 32'(count), 0);
        chk({pfx, "_gid"}, 32'(grant_id), 0);
        chk({pfx, "_did"}, 32'(done_id), 0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_zero("rst");
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One cycle: compare at mid-cycle, then let the accepted requester
    // drop its valid right after the edge.
    task automatic step();
        logic [N-1:0] e_rdy;
        logic         e_busy;
        logic         e_done;
        logic [7:0]   e_cnt;
        int           ph;
        int           own;
        own = -1;
        @(negedge clk);
        #1;
        e_rdy  = '0;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_cnt  = m_count;
        if (cyc < m_idle_at) begin
            ph     = cyc - m_start;
            e_busy = 1'b1;
            if (ph <= m_len) begin
                e_cnt = 8'(ph - 1);
            end else begin
                e_done = 1'b1;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (own < 0 && req_valid[(m_last + k) % N])
                    own = (m_last + k) % N;
            end
            if (own >= 0) e_rdy[own] = 1'b1;
        end
        chk("ready", 32'(req_ready), 32'(e_rdy));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("count", 32'(count), 32'(e_cnt));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
        if (e_done) chk("done_id", 32'(done_id), 32'(m_owner));
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) begin
                acc_id.push_back(i);
                acc_cyc.push_back(cyc);
                if (i == 1) n_g1++;
            end
        end
        if (done) done_cyc.push_back(cyc);
        if (own >= 0) begin
            m_start   = cyc;
            m_len     = int'(req_len[own*W +: W]);
            m_owner   = own;
            m_idle_at = cyc + m_len + 2;
            m_last    = own;
            m_count   = (m_len == 0) ? 8'd0 : 8'(m_len - 1);
        end
        cyc++;
        @(posedge clk);
        #1;
        if (own >= 0) begin
            m_grant        = own;
            req_valid[own] = 1'b0;
        end
    endtask

    task automatic chk_job(input string tag, input int id,
                           input int lat, input int fin);
        chk({tag, "_n"}, 32'(acc_id.size() >= 1 && done_cyc.size() >= 1), 1);
        if (acc_id.size() >= 1 && done_cyc.size() >= 1) begin
            chk({tag, "_id"}, 32'(acc_id[0]), 32'(id));
            chk({tag, "_lat"}, 32'(done_cyc[0] - acc_cyc[0]), 32'(lat));
        end
        chk({tag, "_hold"}, 32'(count), 32'(fin));
    endtask

    initial begin
        int rr_exp [5];
        rr_exp = '{0, 1, 2, 3, 0};

        // single job, len 5 on requester 2
        do_reset();
        clr_logs();
        set_len(2, 5);
        req_valid[2] = 1'b1;
        repeat (9) step();
        chk_job("single", 2, 6, 4);

        // round robin, all valid, len 2
        do_reset();
        clr_logs();
        for (int i = 0; i < N; i++) set_len(i, 2);
        req_valid = '1;
        repeat (18) begin
            step();
            req_valid = '1;
        end
        chk("rr_n", 32'(acc_id.size() >= 5), 1);
        if (acc_id.size() >= 5) begin
            for (int j = 0; j < 5; j++)
                chk("rr_order", 32'(acc_id[j]), 32'(rr_exp[j]));
            for (int j = 1; j < 5; j++)
                chk("rr_gap", 32'(acc_cyc[j] - acc_cyc[j-1]), 4);
        end
        req_valid = '0;

        // zero length on requester 1
        do_reset();
        clr_logs();
        set_len(1, 0);
        req_valid[1] = 1'b1;
        repeat (4) step();
        chk_job("zero", 1, 1, 0);

        // max length on requester 0
        do_reset();
        clr_logs();
        set_len(0, 255);
        req_valid[0] = 1'b1;
        repeat (259) step();
        chk_job("max", 0, 256, 254);

        // reset in the middle of a len 10 job
        do_reset();
        clr_logs();
        set_len(0, 10);
        req_valid[0] = 1'b1;
        repeat (4) step();
        chk("mid_cnt3", 32'(count), 3);
        #6 reset = 1'b1;
        #1 chk_zero("mid");
        set_len(0, 2);
        set_len(3, 2);
        req_valid = 4'b1001;
        #3 reset = 1'b0;
        model_reset();
        clr_logs();
        repeat (10) step();
        chk("mid_nodone", 32'(done_cyc.size() >= 1 && done_cyc[0] == acc_cyc[0] + 3), 1);
        chk("mid_first", 32'(acc_id.size() >= 1 && acc_id[0] == 0), 1);
        req_valid = '0;

        // requester 1 withdraws during requester 0's run
        do_reset();
        clr_logs();
        set_len(0, 4);
        set_len(1, 3);
        req_valid = 4'b0011;
        repeat (2) step();
        req_valid[1] = 1'b0;
        repeat (8) step();
        chk("hold_g1", 32'(n_g1), 0);
        chk_job("hold", 0, 5, 3);

        // random jobs
        do_reset();
        for (int s = 0; s < 600; s++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 19) == 0)
                        set_len(i, int'($urandom_range(0, 255)));
                    else
                        set_len(i, int'($urandom_range(0, 6)));
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && cyc < m_idle_at &&
                             $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
